uart_tx: RTL and testbench

Serializing UART transmitter, the transmit-side counterpart of the `uart_rx` receiver. It accepts one byte per valid/ready handshake and drives an 8N1 frame, LSB first, on a single serial line. The frame is optionally extended with a parity bit. It uses the same `CLKS_PER_BIT` timing model as the receiver, so a `uart_tx` output wired to a `uart_rx` input must loop back byte-exact.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame constants shared by uart_tx and uart_rx.
// No ports; imported with import uart_pkg::*.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int DEF_CLKS_PER_BIT = 521;
  localparam int DATA_BITS        = 8;
  localparam int STOP_BITS        = 1;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake into the transmitter.
// tx_data/tx_valid from master, tx_ready from slave.
interface uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter, tick_o on the last cycle of each bit.
// Ports: clk_i, rst_i (sync, high), clr_i (hold at 0), tick_o.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 521
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer, LSB first; parity bit when UART_TX_PARITY_EN set.
// Ports: tx_clk, rst (sync, high), bus (uart_tx_if.slave), tx_out, tx_busy, tx_done.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic         tx_clk,
  input  logic         rst,
  uart_tx_if.slave     bus,
  output logic         tx_out,
  output logic         tx_busy,
  output logic         tx_done
);

  uart_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic tx_out_q, tx_out_d;
  logic done_q, done_d;
  logic tick;
  logic accept;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  assign bus.tx_ready = (state_q == IDLE);
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign tx_busy      = !bus.tx_ready;
  assign tx_out       = tx_out_q;
  assign tx_done      = done_q;

  // Counter is held at 0 while idle so every start bit gets a full period.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk_i (tx_clk),
    .rst_i (rst),
    .clr_i (state_q == IDLE),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = bus.tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = (^bus.tx_data) ^ PARITY_ODD;
`endif
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          bit_d   = bit_q + 3'd1;
          shift_d = shift_q >> 1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx_out stays registered.
  always_comb begin
    tx_out_d = 1'b1;
    unique case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_out_d = par_d;
`endif
      default: tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      tx_out_q <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      tx_out_q <= tx_out_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a line-decoding receiver model.
// Honours UART_TX_PARITY_EN (even parity, PARITY_ODD=0).
module tb_uart_tx;

  localparam int CPB = 521;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  typedef struct {
    logic [10:0] bits;
    int          start;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic tx_out, tx_busy, tx_done;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  rec_t rec_q[$];
  int   acc_q[$];
  int   done_q[$];

  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (1'b0)
  ) dut (
    .tx_clk (clk),
    .rst    (rst),
    .bus    (bus),
    .tx_out (tx_out),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.tx_valid && bus.tx_ready) acc_q.push_back(cyc);
    if (tx_done) done_q.push_back(cyc);
  end

  initial begin : rx_model
    rec_t r;
    forever begin
      @(negedge clk);
      if (!rst && tx_out === 1'b0) begin
        r.start = cyc;
        r.bits  = '1;
        repeat (CPB / 2) @(negedge clk);
        r.bits[0] = tx_out;
        for (int i = 1; i < NB; i++) begin
          repeat (CPB) @(negedge clk);
          r.bits[i] = tx_out;
        end
        rec_q.push_back(r);
      end
    end
  end

  initial begin : watchdog
    #(150000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    rec_q.delete();
    acc_q.delete();
    done_q.delete();
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send(input logic [7:0] b, input bit hold);
    bit got = 1'b0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (bus.tx_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < n * (FRAME + 2) + 2 * CPB; i++) begin
      @(negedge clk);
      if (rec_q.size() >= n && done_q.size() >= n) break;
    end
    repeat (5) @(negedge clk);
    check("frames_seen", 32'(rec_q.size()), 32'(n));
    check("done_count", 32'(done_q.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  logic [7:0] vec_b[5] = '{8'h00, 8'hFF, 8'h55, 8'hA5, 8'h03};
  logic       vec_p[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin : main
    bit low_seen;
    int a0;
    rst          = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    low_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) low_seen = 1'b1;
    end
    check("idle_line", 32'(low_seen), 32'd0);
    check("idle_no_accept", 32'(acc_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // 0xE3 frame, data changed right after acceptance
    clear_q();
    send(8'hE3, 1'b0);
    bus.tx_data = 8'h5A;
    @(negedge clk);
    check("e3_busy", 32'(tx_busy), 32'd1);
    check("e3_ready", 32'(bus.tx_ready), 32'd0);
    check("e3_start_lvl", 32'(tx_out), 32'd0);
    wait_frames(1);
    if (rec_q.size() >= 1 && acc_q.size() >= 1 && done_q.size() >= 1) begin
      check("e3_bits", 32'(rec_q[0].bits), 32'h7C6);
      check("e3_start_lat", 32'(rec_q[0].start - acc_q[0]), 32'd1);
      check("e3_done_cyc", 32'(done_q[0] - acc_q[0]), 32'(FRAME + 1));
    end

    // loopback bytes
    for (int k = 0; k < 5; k++) begin
      clear_q();
      send(vec_b[k], 1'b0);
      wait_frames(1);
      if (rec_q.size() >= 1) begin
        check($sformatf("lb_byte_%0h", vec_b[k]),
              32'(rec_q[0].bits[8:1]), 32'(vec_b[k]));
        check($sformatf("lb_start_%0h", vec_b[k]),
              32'(rec_q[0].bits[0]), 32'd0);
`ifdef UART_TX_PARITY_EN
        check($sformatf("lb_par_%0h", vec_b[k]),
              32'(rec_q[0].bits[9]), 32'(vec_p[k]));
        check($sformatf("lb_stop_%0h", vec_b[k]),
              32'(rec_q[0].bits[10]), 32'd1);
`else
        check($sformatf("lb_stop_%0h", vec_b[k]),
              32'(rec_q[0].bits[9]), 32'd1);
        if (vec_p[k]) check("lb_par_unused", 32'd0, 32'd1);
`endif
      end
    end

    // back-to-back
    clear_q();
    send(8'h12, 1'b1);
    send(8'h34, 1'b0);
    wait_frames(2);
    if (rec_q.size() >= 2 && acc_q.size() >= 2 && done_q.size() >= 1) begin
      check("b2b_byte0", 32'(rec_q[0].bits[8:1]), 32'h12);
      check("b2b_byte1", 32'(rec_q[1].bits[8:1]), 32'h34);
      check("b2b_gap", 32'(rec_q[1].start - rec_q[0].start), 32'(FRAME + 1));
      check("b2b_acc", 32'(acc_q[1]), 32'(done_q[0]));
    end

    // busy protection
    clear_q();
    send(8'h3C, 1'b0);
    repeat (300) @(posedge clk);
    #1;
    send(8'h99, 1'b0);
    wait_frames(2);
    if (rec_q.size() >= 2 && acc_q.size() >= 2) begin
      check("busy_inflight", 32'(rec_q[0].bits[8:1]), 32'h3C);
      check("busy_next", 32'(rec_q[1].bits[8:1]), 32'h99);
      check("busy_acc_gap", 32'(acc_q[1] - acc_q[0]), 32'(FRAME + 1));
    end

    // reset during data bit 3 of 0xF0 (bit 3 is low)
    clear_q();
    send(8'hF0, 1'b0);
    repeat (4 * CPB + CPB / 2 - 1) @(posedge clk);
    #1;
    @(negedge clk);
    check("prerst_line", 32'(tx_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_tx_out", 32'(tx_out), 32'd1);
    check("mrst_ready", 32'(bus.tx_ready), 32'd1);
    check("mrst_busy", 32'(tx_busy), 32'd0);
    a0 = done_q.size();
    low_seen = 1'b0;
    repeat (FRAME + CPB) begin
      @(negedge clk);
      if (tx_out !== 1'b1) low_seen = 1'b1;
    end
    check("mrst_line_high", 32'(low_seen), 32'd0);
    check("mrst_no_done", 32'(done_q.size()), 32'(a0));
    check("mrst_no_done0", 32'(a0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
